// File: rtl/pkt_act_exec.sv
// pkt_act_exec: writes per-packet forwarding actions into FAST metadata and keeps egress counters.
// 1 clk latency, no backpressure (excess actions are lost, see act_ovf); `PKT_PCP_REMARK_EN adds VLAN PCP remark.
module pkt_act_exec #(
  parameter int ACT_FIFO_DEPTH = 4,
  parameter int ACT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [133:0]         in_pkt_data,
  input  logic                 in_pkt_data_wr,
  input  logic [ACT_WIDTH-1:0] in_act,
  input  logic                 in_act_wr,
  output logic [133:0]         out_pkt_data,
  output logic                 out_pkt_data_wr,
  output logic                 out_pkt_valid,
  output logic                 out_pkt_valid_wr,
  output logic                 act_fifo_full,
  output logic                 act_ovf,
  output logic [63:0]          esw_pktout_cnt,
  output logic [63:0]          esw_pktdrop_cnt
);

  localparam int AW = $clog2(ACT_FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, MD1, HDR, BODY, DROP} state_t;
  state_t state_q, state_d;

  logic [ACT_WIDTH-1:0] fifo_mem [ACT_FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          fifo_cnt, fifo_cnt_d;

  logic                 is_head, is_tail, fifo_empty;
  logic                 use_bypass, fifo_pop, fifo_push, act_avail, act_lost;
  logic [ACT_WIDTH-1:0] act_sel;
  logic                 unused_act;

  logic [133:0] data_d;
  logic         data_wr_d, valid_d, valid_wr_d, out_inc, drop_inc;

  assign is_head    = in_pkt_data_wr && (in_pkt_data[133:132] == 2'b01);
  assign is_tail    = in_pkt_data_wr && (in_pkt_data[133:132] == 2'b10);
  assign fifo_empty = (fifo_cnt == '0);

  // Every head consumes an action if one exists; with an empty FIFO a same-cycle action bypasses storage.
  assign use_bypass = is_head && fifo_empty && in_act_wr;
  assign fifo_pop   = is_head && !fifo_empty;
  assign act_avail  = fifo_pop || use_bypass;
  assign act_sel    = fifo_empty ? in_act : fifo_mem[rd_ptr];
  assign fifo_push  = in_act_wr && !use_bypass && (!act_fifo_full || fifo_pop);
  assign act_lost   = in_act_wr && !use_bypass && act_fifo_full && !fifo_pop;

  always_comb begin
    fifo_cnt_d = fifo_cnt;
    if (fifo_push && !fifo_pop)
      fifo_cnt_d = fifo_cnt + 1'b1;
    else if (!fifo_push && fifo_pop)
      fifo_cnt_d = fifo_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (fifo_push)
      fifo_mem[wr_ptr] <= in_act;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_cnt      <= '0;
      act_fifo_full <= 1'b0;
      act_ovf       <= 1'b0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt      <= fifo_cnt_d;
      act_fifo_full <= (fifo_cnt_d == (AW+1)'(ACT_FIFO_DEPTH));
      if (act_lost) act_ovf <= 1'b1;
    end
  end

`ifdef PKT_PCP_REMARK_EN
  logic [2:0] pcp_q, pcp_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pcp_q <= '0;
    else        pcp_q <= pcp_d;
  end

  assign unused_act = ^act_sel[8:6];
`else
  assign unused_act = ^{act_sel[14:12], act_sel[8:6]};
`endif

  always_comb begin
    state_d    = state_q;
    data_d     = '0;
    data_wr_d  = 1'b0;
    valid_d    = 1'b0;
    valid_wr_d = 1'b0;
    out_inc    = 1'b0;
    drop_inc   = 1'b0;
`ifdef PKT_PCP_REMARK_EN
    pcp_d      = pcp_q;
`endif
    if (is_head) begin
      // A head inside a packet closes the truncated one as bad, then starts afresh.
      if (state_q inside {MD1, HDR, BODY}) begin
        valid_wr_d = 1'b1;
        drop_inc   = 1'b1;
      end else if (state_q == DROP) begin
        drop_inc   = 1'b1;
      end
      if (act_avail && !act_sel[15]) begin
        data_wr_d        = 1'b1;
        data_d           = in_pkt_data;
        data_d[109:104]  = act_sel[5:0];
        data_d[103:101]  = act_sel[11:9];
        state_d          = MD1;
`ifdef PKT_PCP_REMARK_EN
        pcp_d            = act_sel[14:12];
`endif
      end else begin
        state_d = DROP;
      end
    end else if (in_pkt_data_wr) begin
      case (state_q)
        MD1, HDR, BODY: begin
          data_wr_d = 1'b1;
          data_d    = in_pkt_data;
`ifdef PKT_PCP_REMARK_EN
          if (state_q == HDR && in_pkt_data[31:16] == 16'h8100)
            data_d[15:13] = pcp_q;
`endif
          if (is_tail) begin
            valid_wr_d = 1'b1;
            valid_d    = 1'b1;
            out_inc    = 1'b1;
            state_d    = IDLE;
          end else if (state_q == MD1) begin
            state_d = HDR;
          end else begin
            state_d = BODY;
          end
        end
        DROP: begin
          if (is_tail) begin
            drop_inc = 1'b1;
            state_d  = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      out_pkt_data     <= '0;
      out_pkt_data_wr  <= 1'b0;
      out_pkt_valid    <= 1'b0;
      out_pkt_valid_wr <= 1'b0;
      esw_pktout_cnt   <= '0;
      esw_pktdrop_cnt  <= '0;
    end else begin
      state_q          <= state_d;
      out_pkt_data     <= data_d;
      out_pkt_data_wr  <= data_wr_d;
      out_pkt_valid    <= valid_d;
      out_pkt_valid_wr <= valid_wr_d;
      if (out_inc)  esw_pktout_cnt  <= esw_pktout_cnt + 64'd1;
      if (drop_inc) esw_pktdrop_cnt <= esw_pktdrop_cnt + 64'd1;
    end
  end

endmodule
